shblk_byte_sched: RTL and testbench
===================================

Name: shblk_byte_sched

Overview:
- Byte scheduler for the masked AES datapath.
- Captures a full d-share state in block representation: share j occupies bits [128j+127:128j]; byte k of share j sits at offset 8k within that share.
- Issues the state one byte per handshake in bit representation to the downstream masked S-box/byte lane.
- Owns sequencing, byte indexing and back-pressure between the state register and the byte-serial datapath.

Parameters:
d, 2, number of shares (>=2)
nbytes, 16, bytes per state (>=2); CW = $clog2(nbytes)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  in_shblk valid
in_ready  output  1  scheduler can accept a state
in_shblk  input  d*8*nbytes  shared state, block representation
out_valid  output  1  out_shbit holds a valid shared byte
out_ready  input  1  downstream accepts the byte
out_shbit  output  8*d  current byte, bit representation: bit d*i+j = share j bit i
out_idx  output  CW  index k of the current byte
out_last  output  1  high when out_idx == nbytes-1 and out_valid
flush  input  1  synchronous abort, returns to IDLE
busy  output  1  state != IDLE

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE, counter = 0, state register = 0.
  - Outputs: in_ready = 1 after reset release, out_valid = 0, out_idx = 0, out_last = 0, busy = 0.
- Two-state FSM: IDLE, ISSUE.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - On in_valid && in_ready: register in_shblk, counter = 0, go to ISSUE.
- ISSUE:
  - in_ready = 0, out_valid = 1.
  - out_shbit is a combinational mux of the held register at byte counter; out_idx = counter.
  - out_valid && out_ready with counter < nbytes-1: counter += 1.
  - out_valid && out_ready with counter == nbytes-1: counter = 0, go to IDLE.
  - out_ready low: hold out_shbit, out_idx and out_valid stable (AXI-style; valid never drops without a handshake, except on flush).
- Latency and throughput:
  - State captured at edge T; byte 0 is valid from T+1.
  - Minimum nbytes+1 cycles per state.
  - No overlap: a new state is accepted only in IDLE, i.e. the cycle after the last byte handshake.
- flush:
  - Sampled every cycle; takes priority over every handshake.
  - Next state IDLE, counter = 0. A byte handshaking in the same cycle is discarded; the downstream must ignore it.
  - In IDLE, flush also blocks capture: in_ready is forced 0 while flush = 1.
- Share mapping: for every byte and every i<8, j<d, out_shbit[d*i+j] = in_shblk[8*nbytes*j + 8*k + i]. Pure wiring; no share recombination, no XOR between shares anywhere in the block.
- counter never exceeds nbytes-1; no wrap except the explicit return to 0.
- Non-power-of-two nbytes must work.

Optional Feature:
SHBLK_SCHED_CLEAR_EN
- Defined:
  - The held state register is zeroed on the cycle the last byte is accepted, and on flush.
  - out_shbit is forced to 0 whenever out_valid = 0. No stale shares stay observable.
- Undefined:
  - The register retains its last contents.
  - out_shbit always shows the mux output at counter, even in IDLE.

Test Plan:
- Reset then idle (d=2, nbytes=16) -> in_ready=1, out_valid=0, busy=0, out_idx=0.
- Load: share0 byte k = k, share1 all 0xFF; out_ready=1 held -> 16 consecutive bytes from T+1.
  - Byte 0: out_shbit=0xAAAA. Byte 1: 0xAAAB. Byte 15: 0xAAFF.
  - out_last only on idx 15; in_ready returns at T+17.
- Back-pressure: out_ready low for 5 cycles at idx 3 -> out_idx=3 and out_shbit stable for all 5 cycles, then idx 4 next.
- flush asserted at idx 7 while out_ready=1 -> IDLE next cycle, out_valid=0, in_ready=1.
  - Next load restarts at idx 0.
  - With SHBLK_SCHED_CLEAR_EN, out_shbit=0 after flush.
- Async reset mid-ISSUE (idx 9) -> outputs at reset values immediately, without waiting for a clock edge; re-load works normally.
- in_valid held high during ISSUE with a different state -> not captured until IDLE; the second state is then emitted intact.

Source files
------------

// File: rtl/shblk_byte_sched_if.sv
// Handshake bundle between the shared-state source, the byte scheduler and the
// byte-serial masked datapath. slave = scheduler view, master = driver view.
interface shblk_byte_sched_if #(
  parameter int d      = 2,
  parameter int nbytes = 16
);
  localparam int CW = $clog2(nbytes);

  logic                    in_valid;
  logic                    in_ready;
  logic [d*8*nbytes-1:0]   in_shblk;
  logic                    out_valid;
  logic                    out_ready;
  logic [8*d-1:0]          out_shbit;
  logic [CW-1:0]           out_idx;
  logic                    out_last;
  logic                    flush;
  logic                    busy;

  modport slave (
    input  in_valid, in_shblk, out_ready, flush,
    output in_ready, out_valid, out_shbit, out_idx, out_last, busy
  );

  modport master (
    output in_valid, in_shblk, out_ready, flush,
    input  in_ready, out_valid, out_shbit, out_idx, out_last, busy
  );
endinterface

// File: rtl/shblk_byte_sched.sv
// Byte scheduler: captures a d-share state and issues it one shared byte per handshake.
// Optional macro SHBLK_SCHED_CLEAR_EN wipes the held state after use and blanks idle output.
module shblk_byte_sched #(
  parameter int d      = 2,
  parameter int nbytes = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  shblk_byte_sched_if.slave    bus
);
  localparam int CW = $clog2(nbytes);
  localparam logic [CW-1:0] LAST = CW'(nbytes - 1);

  typedef enum logic [0:0] {IDLE, ISSUE} state_t;

  state_t                 state_p0;
  logic [CW-1:0]          cnt_p0;
  logic [d*8*nbytes-1:0]  data_p0;
  logic                   vld_p0;
  logic                   rdy_p0;
  logic                   take;
  logic [8*d-1:0]         shbit;
  logic [7:0]             lane [d][nbytes];

  // Flush wins over capture, so the ready seen upstream must already reflect it.
  assign take = bus.in_valid && rdy_p0 && !bus.flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p0 <= IDLE;
      cnt_p0   <= '0;
      data_p0  <= '0;
      vld_p0   <= 1'b0;
      rdy_p0   <= 1'b1;
    end else if (bus.flush) begin
      state_p0 <= IDLE;
      cnt_p0   <= '0;
      vld_p0   <= 1'b0;
      rdy_p0   <= 1'b1;
`ifdef SHBLK_SCHED_CLEAR_EN
      data_p0  <= '0;
`endif
    end else begin
      case (state_p0)
        IDLE: begin
          if (take) begin
            data_p0  <= bus.in_shblk;
            cnt_p0   <= '0;
            state_p0 <= ISSUE;
            vld_p0   <= 1'b1;
            rdy_p0   <= 1'b0;
          end
        end
        ISSUE: begin
          if (bus.out_ready) begin
            if (cnt_p0 == LAST) begin
              cnt_p0   <= '0;
              state_p0 <= IDLE;
              vld_p0   <= 1'b0;
              rdy_p0   <= 1'b1;
`ifdef SHBLK_SCHED_CLEAR_EN
              data_p0  <= '0;
`endif
            end else begin
              cnt_p0 <= cnt_p0 + 1'b1;
            end
          end
        end
        default: begin
          state_p0 <= IDLE;
          vld_p0   <= 1'b0;
          rdy_p0   <= 1'b1;
        end
      endcase
    end
  end

  // Block-to-bit representation is pure wiring: share j bit i lands at d*i+j.
  for (genvar j = 0; j < d; j++) begin : g_share
    for (genvar k = 0; k < nbytes; k++) begin : g_byte
      assign lane[j][k] = data_p0[8*nbytes*j + 8*k +: 8];
    end
    for (genvar i = 0; i < 8; i++) begin : g_bit
      assign shbit[d*i + j] = lane[j][cnt_p0][i];
    end
  end

`ifdef SHBLK_SCHED_CLEAR_EN
  assign bus.out_shbit = vld_p0 ? shbit : '0;
`else
  assign bus.out_shbit = shbit;
`endif

  assign bus.in_ready  = rdy_p0 && !bus.flush;
  assign bus.out_valid = vld_p0;
  assign bus.out_idx   = cnt_p0;
  assign bus.out_last  = vld_p0 && (cnt_p0 == LAST);
  assign bus.busy      = (state_p0 != IDLE);
endmodule

// File: tb/tb_shblk_byte_sched.sv
// Bench for shblk_byte_sched: directed scenarios plus random states and back-pressure,
// compared against a share-mapping model of the scheduler's contract.
`define CHK(tag, o, e) chk(tag, 32'(o), 32'(e))

module tb_shblk_byte_sched;
  localparam int D  = 2;
  localparam int NB = 16;
  localparam int SW = D*8*NB;
  localparam int OW = 8*D;

  logic clk;
  logic rst_n;
  int   n_chk  = 0;
  int   n_fail = 0;

  shblk_byte_sched_if #(.d(D), .nbytes(NB)) bus ();

  shblk_byte_sched #(.d(D), .nbytes(NB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Byte k of the state as the downstream must see it: bit d*i+j = share j bit i.
  function automatic logic [OW-1:0] exp_byte(input logic [SW-1:0] s, input int k);
    logic [OW-1:0] r;
    r = '0;
    for (int j = 0; j < D; j++)
      for (int i = 0; i < 8; i++)
        r[D*i + j] = s[8*NB*j + 8*k + i];
    return r;
  endfunction

  function automatic logic [SW-1:0] rand_state();
    logic [SW-1:0] r;
    r = '0;
    for (int w = 0; w < SW/32; w++) r[32*w +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk_idle(input string tag);
    `CHK({tag, "_in_ready"},  bus.in_ready,  1);
    `CHK({tag, "_out_valid"}, bus.out_valid, 0);
    `CHK({tag, "_busy"},      bus.busy,      0);
    `CHK({tag, "_out_idx"},   bus.out_idx,   0);
    `CHK({tag, "_out_last"},  bus.out_last,  0);
  endtask

  task automatic load(input logic [SW-1:0] s);
    int w;
    w = 0;
    while (!bus.in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    `CHK("load_in_ready", bus.in_ready, 1);
    bus.in_shblk = s;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_shblk = rand_state();
  endtask

  // mode 0: always ready, 1: random ready, 2: five-cycle stall at idx 3.
  // Returns early (out_ready untouched) when idx reaches stop_at.
  task automatic drain(input logic [SW-1:0] s, input int mode, input int start, input int stop_at);
    int   k;
    int   stall;
    int   budget;
    logic rdy;
    k = start;
    stall = 0;
    budget = 0;
    while (k < NB && k != stop_at) begin
      if (budget > 400) begin
        `CHK("drain_timeout_idx", k, NB);
        return;
      end
      budget++;
      `CHK("out_valid",  bus.out_valid, 1);
      `CHK("out_idx",    bus.out_idx,   k);
      `CHK("out_shbit",  bus.out_shbit, exp_byte(s, k));
      `CHK("out_last",   bus.out_last,  (k == NB-1));
      `CHK("in_ready_issue", bus.in_ready, 0);
      `CHK("busy_issue", bus.busy, 1);
      n_chk++;
      if (bus.out_shbit !== exp_byte(s, k)) begin
        n_fail++;
        $error("FAIL drain_shbit_inline: observed %0h expected %0h", bus.out_shbit, exp_byte(s, k));
      end
      n_chk++;
      if (32'(bus.out_idx) !== 32'(k)) begin
        n_fail++;
        $error("FAIL drain_idx_inline: observed %0d expected %0d", bus.out_idx, k);
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(0, 1));
        default: begin
          if (k == 3 && stall < 5) begin
            rdy = 1'b0;
            stall++;
          end else begin
            rdy = 1'b1;
          end
        end
      endcase
      bus.out_ready = rdy;
      @(negedge clk);
      if (rdy) k++;
    end
    if (k == NB) begin
      bus.out_ready = 1'b0;
      chk_idle("after_last");
    end
  endtask

  logic [SW-1:0] s1, s2, pat;

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_shblk  = '0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;

    #1;
    `CHK("rst_out_valid", bus.out_valid, 0);
    `CHK("rst_busy",      bus.busy,      0);
    `CHK("rst_out_idx",   bus.out_idx,   0);
    `CHK("rst_out_last",  bus.out_last,  0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_idle("reset_release");
    n_chk++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $error("FAIL reset_in_ready_inline: observed %0b", bus.in_ready);
    end
    n_chk++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $error("FAIL reset_out_valid_inline: observed %0b", bus.out_valid);
    end
    @(negedge clk);

    // Directed pattern: share0 byte k = k, share1 all ones.
    pat = '0;
    for (int k = 0; k < NB; k++) pat[8*k +: 8] = 8'(k);
    pat[8*NB +: 8*NB] = '1;
    load(pat);
    `CHK("pat_b0", bus.out_shbit, 16'hAAAA);
    n_chk++;
    if (bus.out_shbit !== 16'hAAAA) begin
      n_fail++;
      $error("FAIL pat_b0_inline: observed %0h", bus.out_shbit);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    `CHK("pat_b1", bus.out_shbit, 16'hAAAB);
    drain(pat, 0, 1, 15);
    `CHK("pat_b15",   bus.out_shbit, 16'hAAFF);
    `CHK("pat_last15", bus.out_last, 1);
    n_chk++;
    if (bus.out_shbit !== 16'hAAFF) begin
      n_fail++;
      $error("FAIL pat_b15_inline: observed %0h", bus.out_shbit);
    end
    drain(pat, 0, 15, -1);

    // Back-pressure at idx 3.
    s1 = rand_state();
    load(s1);
    drain(s1, 2, 0, -1);

    // Flush mid-issue at idx 7 with out_ready high.
    s1 = rand_state();
    load(s1);
    drain(s1, 0, 0, 7);
    `CHK("pre_flush_idx", bus.out_idx, 7);
    bus.flush = 1'b1;
    @(negedge clk);
    `CHK("flush_out_valid", bus.out_valid, 0);
    `CHK("flush_busy",      bus.busy,      0);
    `CHK("flush_out_idx",   bus.out_idx,   0);
    `CHK("flush_in_ready_blocked", bus.in_ready, 0);
`ifdef SHBLK_SCHED_CLEAR_EN
    `CHK("flush_shbit", bus.out_shbit, 0);
`else
    `CHK("flush_shbit", bus.out_shbit, exp_byte(s1, 0));
`endif
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    `CHK("post_flush_in_ready", bus.in_ready, 1);
    // Flush in IDLE must block capture.
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_shblk = rand_state();
    #1;
    `CHK("idle_flush_in_ready", bus.in_ready, 0);
    @(negedge clk);
    `CHK("idle_flush_busy",      bus.busy,      0);
    `CHK("idle_flush_out_valid", bus.out_valid, 0);
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    s1 = rand_state();
    load(s1);
    drain(s1, 1, 0, -1);

    // Asynchronous reset mid-issue at idx 9.
    s1 = rand_state();
    load(s1);
    drain(s1, 0, 0, 9);
    `CHK("pre_reset_idx", bus.out_idx, 9);
    #2;
    rst_n = 1'b0;
    #1;
    `CHK("async_rst_out_valid", bus.out_valid, 0);
    `CHK("async_rst_busy",      bus.busy,      0);
    `CHK("async_rst_out_idx",   bus.out_idx,   0);
    `CHK("async_rst_out_last",  bus.out_last,  0);
    `CHK("async_rst_in_ready",  bus.in_ready,  1);
    `CHK("async_rst_shbit",     bus.out_shbit, 0);
    n_chk++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $error("FAIL async_rst_inline: out_valid %0b busy %0b", bus.out_valid, bus.busy);
    end
    bus.out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    s1 = rand_state();
    load(s1);
    drain(s1, 1, 0, -1);

    // in_valid held through ISSUE with a different state.
    s1 = rand_state();
    s2 = rand_state();
    bus.in_shblk = s1;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_shblk = s2;
    drain(s1, 1, 0, -1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    drain(s2, 0, 0, -1);

    // Random states under random back-pressure.
    for (int n = 0; n < 6; n++) begin
      s1 = rand_state();
      load(s1);
      drain(s1, 1, 0, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
